regfile_write_arbiter: RTL
==========================

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, giving the register data width in bits.
REQ-002 The block SHALL have port clk, input, 1: single clock; all state changes on rising edge.
REQ-003 The block SHALL have port rst, input, 1: synchronous reset, active-high.
REQ-004 The block SHALL have port req0, input, 1: requester 0 write request, held high until gnt0 is seen.
REQ-005 The block SHALL have port sel0, input, 1: requester 0 target register (0 or 1), stable while req0 is high.
REQ-006 The block SHALL have port data0, input, DATA_W: requester 0 write data, stable while req0 is high.
REQ-007 The block SHALL have ports req1, sel1 and data1, input, 1/1/DATA_W: requester 1 equivalents of req0, sel0 and data0.
REQ-008 The block SHALL have ports gnt0 and gnt1, output, 1 each: one-cycle grant pulses.
REQ-009 The block SHALL have port regWrite, output, 1: register-file write enable.
REQ-010 The block SHALL have port writeReg, output, 1: register-file write address.
REQ-011 The block SHALL have port writeData, output, DATA_W: register-file write data.
REQ-012 The block SHALL have port ready, output, 1: high once initialisation is complete.
REQ-013 The block SHALL have port collision, output, 1: one-cycle pulse when both requests are sampled with the same target.

Function
REQ-014 The block SHALL use a state machine with states INIT0, INIT1 and RUN; the successor of INIT0 is INIT1, the successor of INIT1 is RUN, and RUN is held until rst.
REQ-015 In INIT0 the next-cycle outputs SHALL be regWrite=1, writeReg=0, writeData=0; in INIT1 they SHALL be regWrite=1, writeReg=1, writeData=0.
REQ-016 gnt0, gnt1 and collision SHALL be 0 throughout INIT0/INIT1; requests seen in those states SHALL be ignored, not queued.
REQ-017 ready SHALL be registered and go to 1 in the first cycle the FSM is in RUN.
REQ-018 In RUN, requester i SHALL be eligible in a cycle only when req_i=1 and gnt_i=0, which prevents a double grant on the cycle the requester drops req.
REQ-019 In RUN, with exactly one requester eligible, the arbiter SHALL grant it.
REQ-020 In RUN, with both requesters eligible, the arbiter SHALL grant the requester other than the last-granted one (round-robin).
REQ-021 The last-granted pointer SHALL update only on a grant.
REQ-022 All outputs SHALL be registered, giving a latency of one cycle from eligible request to outputs.
REQ-023 On a grant to requester i, the next cycle SHALL show gnt_i=1, regWrite=1, writeReg=sel_i and writeData=data_i, all captured at the sampling edge.
REQ-024 When no grant is made, regWrite and gnt0/gnt1 SHALL be 0 and writeReg/writeData SHALL hold their previous values.
REQ-025 At most one of gnt0 and gnt1 SHALL be high in any cycle, and regWrite SHALL equal gnt0|gnt1 while in RUN.
REQ-026 collision SHALL pulse in the output cycle when both were eligible and sel0==sel1; the loser SHALL remain pending and be served on a later cycle.
REQ-027 A requester continuously eligible SHALL be granted within 2 cycles of becoming eligible (no starvation).

Reset
REQ-028 rst=1 at a clock edge SHALL set: state=INIT0, ready=0, gnt0=gnt1=0, regWrite=0, writeReg=0, writeData=0, collision=0, last-granted pointer=1 (so requester 0 wins the first tie).
REQ-029 rst asserted mid-operation, including during INIT1 or on a grant cycle, SHALL abort any pending grant without issuing it and restart from INIT0.
REQ-030 rst SHALL take priority over every other input.

Configuration
REQ-031 When macro REGFILE_ARB_FIXED_PRIO_EN is defined, ties SHALL always go to requester 0, the pointer logic SHALL be removed, and REQ-027 is waived for requester 1.
REQ-032 When REGFILE_ARB_FIXED_PRIO_EN is undefined, the round-robin behaviour of REQ-020 SHALL apply.
REQ-033 All other behaviour SHALL be identical with and without REGFILE_ARB_FIXED_PRIO_EN.

Verification
REQ-034 The bench SHALL cover init: rst high 2 cycles then low -> regWrite=1/writeReg=0/data 0x00, then regWrite=1/writeReg=1/data 0x00, then ready=1 and regWrite=0.
REQ-035 The bench SHALL cover a single request: req0=1, sel0=1, data0=0xA5 in RUN -> next cycle gnt0=1, regWrite=1, writeReg=1, writeData=0xA5; req0 dropped -> no second grant.
REQ-036 The bench SHALL cover a tie: req0/req1 held with sel0=0/data0=0x11 and sel1=1/data1=0x22 -> gnt0 with 0x11 first, then gnt1 with 0x22; collision stays 0.
REQ-037 The bench SHALL cover a collision: both requesters target reg 0 (0x33, 0x44) -> collision=1 with the first grant and both writes complete within 2 cycles; under REGFILE_ARB_FIXED_PRIO_EN, requester 0 always wins repeated ties.
REQ-038 The bench SHALL cover reset mid-operation: rst asserted on the cycle req1 is sampled -> no gnt1 and no regWrite for the request; the init sequence repeats.
REQ-039 The bench SHALL cover starvation: req0 and req1 held high continuously for 10 cycles -> grants alternate 0,1,0,1 and never two consecutive grants to the same requester while both wait.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// Two-requester register-file write arbiter with a two-write init sequence.
// Ports: clk, rst (sync, active-high); req/sel/data per requester in;
//   gnt0/gnt1 grant pulses, regWrite/writeReg/writeData write port,
//   ready after init, collision when both target the same register.
// Build option: REGFILE_ARB_FIXED_PRIO_EN gives ties to requester 0 always.
module regfile_write_arbiter #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              sel0,
  input  logic [DATA_W-1:0] data0,
  input  logic              req1,
  input  logic              sel1,
  input  logic [DATA_W-1:0] data1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              regWrite,
  output logic              writeReg,
  output logic [DATA_W-1:0] writeData,
  output logic              ready,
  output logic              collision
);

  typedef enum logic [1:0] {
    INIT0,
    INIT1,
    RUN
  } state_t;

  state_t state;

  logic elig0;
  logic elig1;
  logic pick0;
  logic pick1;

  // A requester just granted is masked for one cycle so a late req drop
  // cannot produce a second write.
  assign elig0 = req0 & ~gnt0;
  assign elig1 = req1 & ~gnt1;

`ifdef REGFILE_ARB_FIXED_PRIO_EN
  assign pick0 = elig0;
`else
  // lastGnt=1 means requester 1 went last, so requester 0 wins a tie.
  logic lastGnt;

  assign pick0 = elig0 & (~elig1 | lastGnt);

  always_ff @(posedge clk) begin
    if (rst) begin
      lastGnt <= 1'b1;
    end else if (state == RUN && (pick0 | pick1)) begin
      lastGnt <= pick1;
    end
  end
`endif

  assign pick1 = elig1 & ~pick0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= INIT0;
      ready     <= 1'b0;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      regWrite  <= 1'b0;
      writeReg  <= 1'b0;
      writeData <= '0;
      collision <= 1'b0;
    end else begin
      unique case (state)
        INIT0: begin
          gnt0      <= 1'b0;
          gnt1      <= 1'b0;
          collision <= 1'b0;
          regWrite  <= 1'b1;
          writeReg  <= 1'b0;
          writeData <= '0;
          state     <= INIT1;
        end
        INIT1: begin
          gnt0      <= 1'b0;
          gnt1      <= 1'b0;
          collision <= 1'b0;
          regWrite  <= 1'b1;
          writeReg  <= 1'b1;
          writeData <= '0;
          ready     <= 1'b1;
          state     <= RUN;
        end
        RUN: begin
          gnt0      <= pick0;
          gnt1      <= pick1;
          regWrite  <= pick0 | pick1;
          collision <= elig0 & elig1 & (sel0 == sel1);
          unique case (1'b1)
            pick0: begin
              writeReg  <= sel0;
              writeData <= data0;
            end
            pick1: begin
              writeReg  <= sel1;
              writeData <= data1;
            end
            default: ;
          endcase
        end
        default: begin
          state <= INIT0;
        end
      endcase
    end
  end

endmodule
